// File: rtl/fifo_wr_arb_pkg.sv
// Shared types for the FIFO write-port arbiter: FSM encoding,
// default watchdog limit and the round-robin distance helper.
package fifo_wr_arb_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_e;

    localparam int DEF_TIMEOUT = 255;
    localparam int CNT_W       = 16;

    // Distance of requester j from the slot after last, with wrap.
    // The smallest distance wins, so last itself has the lowest priority.
    function automatic int rr_dist(int j, int last, int n);
        return (j - last - 1 + 2 * n) % n;
    endfunction

endpackage

// File: rtl/fifo_wr_arb_if.sv
// Requester-side and FIFO-side signals of the write arbiter.
// slave: arbiter view; master: producer/FIFO view.
interface fifo_wr_arb_if #(
    parameter int N  = 4,
    parameter int IW = 2
);
    logic [N-1:0]   iReqValid;
    logic [8*N-1:0] iReqData;
    logic [N-1:0]   iReqLast;
    logic [N-1:0]   oReqReady;
    logic           oFifoWrEn;
    logic [7:0]     oFifoWrData;
    logic           iFifoWrFull;
    logic [IW-1:0]  oGrantIdx;
    logic           oBusy;
    logic           oAbort;

    modport slave (
        input  iReqValid, iReqData, iReqLast, iFifoWrFull,
        output oReqReady, oFifoWrEn, oFifoWrData,
        output oGrantIdx, oBusy, oAbort
    );

    modport master (
        output iReqValid, iReqData, iReqLast, iFifoWrFull,
        input  oReqReady, oFifoWrEn, oFifoWrData,
        input  oGrantIdx, oBusy, oAbort
    );
endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set req bit above last_idx.
// Ports: req (vector), last_idx (in); found, idx (out).
module rr_pick
    import fifo_wr_arb_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last_idx,
    output logic          found,
    output logic [IW-1:0] idx
);

    int best;

    always_comb begin
        found = |req;
        idx   = '0;
        best  = N;
        for (int j = 0; j < N; j++) begin
            if (req[j] && rr_dist(j, int'(last_idx), N) < best) begin
                best = rr_dist(j, int'(last_idx), N);
                idx  = IW'(j);
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arb.sv
// Packet-locked round-robin arbiter for the shared FIFO write port.
// Ports: iClk, iRst (async high), bus (requesters, FIFO write, status).
module fifo_wr_arb
    import fifo_wr_arb_pkg::*;
#(
    parameter int pNumReq  = 4,
    parameter int pIdxW    = 2,
    parameter int pTimeout = DEF_TIMEOUT
) (
    input  logic          iClk,
    input  logic          iRst,
    fifo_wr_arb_if.slave  bus
);

    localparam logic [pIdxW-1:0] LAST_RST = pIdxW'(pNumReq - 1);
    localparam logic [CNT_W:0]   TMO      = (CNT_W + 1)'(pTimeout);

    arb_state_e         state_q, state_d;
    logic [pIdxW-1:0]   g_q, g_d;
    logic [pIdxW-1:0]   last_q, last_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               abort_q, abort_d;

    logic               pick_found;
    logic [pIdxW-1:0]   pick_idx;
    logic               g_valid;
    logic               g_last;
    logic [7:0]         g_data;
    logic               xfer;
    logic [CNT_W:0]     cnt_inc;
    logic [pNumReq-1:0] ready;
    logic               wr_en;
    logic [7:0]         wr_data;

    rr_pick #(
        .N  (pNumReq),
        .IW (pIdxW)
    ) u_pick (
        .req      (bus.iReqValid),
        .last_idx (last_q),
        .found    (pick_found),
        .idx      (pick_idx)
    );

    // Mux out the granted requester's stream.
    always_comb begin
        g_valid = 1'b0;
        g_last  = 1'b0;
        g_data  = 8'h00;
        for (int k = 0; k < pNumReq; k++) begin
            if (g_q == pIdxW'(k)) begin
                g_valid = bus.iReqValid[k];
                g_last  = bus.iReqLast[k];
                g_data  = bus.iReqData[8*k +: 8];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        g_d     = g_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        abort_d = 1'b0;
        ready   = '0;
        wr_en   = 1'b0;
        wr_data = 8'h00;
        xfer    = 1'b0;
        cnt_inc = {1'b0, cnt_q} + 1'b1;

        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (pick_found) begin
                    g_d     = pick_idx;
                    state_d = LOCKED;
                end
            end
            LOCKED: begin
                for (int k = 0; k < pNumReq; k++) begin
                    if (g_q == pIdxW'(k)) begin
                        ready[k] = !bus.iFifoWrFull;
                    end
                end
                xfer = g_valid && !bus.iFifoWrFull;
                if (xfer) begin
                    wr_en   = 1'b1;
                    wr_data = g_data;
                end
                // Valid-but-full stalls keep the watchdog cleared.
                if (g_valid) begin
                    cnt_d = '0;
                end else if (cnt_inc == TMO) begin
                    abort_d = 1'b1;
                    state_d = IDLE;
                    last_d  = g_q;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc[CNT_W-1:0];
                end
                if (xfer && g_last) begin
                    state_d = IDLE;
                    last_d  = g_q;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            state_q <= IDLE;
            g_q     <= '0;
            last_q  <= LAST_RST;
            cnt_q   <= '0;
            abort_q <= 1'b0;
        end else begin
            state_q <= state_d;
            g_q     <= g_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            abort_q <= abort_d;
        end
    end

    assign bus.oReqReady   = ready;
    assign bus.oFifoWrEn   = wr_en;
    assign bus.oFifoWrData = wr_data;
    assign bus.oGrantIdx   = g_q;
    assign bus.oBusy       = (state_q == LOCKED);
    assign bus.oAbort      = abort_q;

endmodule
